// File: rtl/cbfp_bitrev_reorder.sv
// Bit-reversed to natural-order reorder buffer for the 512-point CBFP FFT output.
// Optional macro CBFP_REORDER_FRAME_TAG_EN adds frame_start_out / frame_cnt_out.
module cbfp_bitrev_reorder #(
    parameter int DATA_W = 13,
    parameter int LANES  = 16,
    parameter int N_PTS  = 512,
    parameter int ADDR_W = 9
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      valid_in,
    input  logic [LANES*DATA_W-1:0]   data_re_in,
    input  logic [LANES*DATA_W-1:0]   data_im_in,
    output logic                      valid_out,
    output logic [LANES*DATA_W-1:0]   data_re_out,
    output logic [LANES*DATA_W-1:0]   data_im_out
`ifdef CBFP_REORDER_FRAME_TAG_EN
    ,
    output logic                      frame_start_out,
    output logic [7:0]                frame_cnt_out
`endif
);

    localparam int LANE_W = $clog2(LANES);
    localparam int BEAT_W = ADDR_W - LANE_W;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_PTS / LANES - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_READ = 1'b1
    } state_t;

    state_t                    state_q;
    logic [BEAT_W-1:0]         wr_beat_q;
    logic [BEAT_W-1:0]         rd_beat_q;
    logic                      wr_bank_q;
    logic                      rd_bank_q;
    logic [1:0]                bank_full_q;
    logic [1:0]                bank_full_d;
    logic                      valid_q;
    logic [LANES*DATA_W-1:0]   data_re_q;
    logic [LANES*DATA_W-1:0]   data_im_q;

    logic                      rd_go;
    logic                      rd_sel_bank;
    logic [LANES*DATA_W-1:0]   rd_re;
    logic [LANES*DATA_W-1:0]   rd_im;

    // Sample storage: two banks, linear input order; never reset.
    logic [DATA_W-1:0] mem_re_q [2][N_PTS];
    logic [DATA_W-1:0] mem_im_q [2][N_PTS];

    function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        for (int i = 0; i < ADDR_W; i++) begin
            r[i] = a[ADDR_W-1-i];
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (valid_in) begin
            for (int k = 0; k < LANES; k++) begin
                mem_re_q[wr_bank_q][{wr_beat_q, LANE_W'(k)}] <= data_re_in[k*DATA_W +: DATA_W];
                mem_im_q[wr_bank_q][{wr_beat_q, LANE_W'(k)}] <= data_im_in[k*DATA_W +: DATA_W];
            end
        end
    end

    // IDLE emits beat 0 the cycle a bank turns full, so a bank completing on
    // the reader's last beat still follows with no bubble.
    always_comb begin
        rd_go       = 1'b0;
        rd_sel_bank = rd_bank_q;
        if (state_q == S_READ) begin
            rd_go = 1'b1;
        end else if (bank_full_q[0]) begin
            rd_go       = 1'b1;
            rd_sel_bank = 1'b0;
        end else if (bank_full_q[1]) begin
            rd_go       = 1'b1;
            rd_sel_bank = 1'b1;
        end
    end

    always_comb begin
        rd_re = '0;
        rd_im = '0;
        for (int l = 0; l < LANES; l++) begin
            rd_re[l*DATA_W +: DATA_W] = mem_re_q[rd_sel_bank][bitrev({rd_beat_q, LANE_W'(l)})];
            rd_im[l*DATA_W +: DATA_W] = mem_im_q[rd_sel_bank][bitrev({rd_beat_q, LANE_W'(l)})];
        end
    end

    always_comb begin
        bank_full_d = bank_full_q;
        if (rd_go && (rd_beat_q == LAST_BEAT)) begin
            bank_full_d[rd_sel_bank] = 1'b0;
        end
        if (valid_in && (wr_beat_q == LAST_BEAT)) begin
            bank_full_d[wr_bank_q] = 1'b1;
        end
    end

`ifdef CBFP_REORDER_FRAME_TAG_EN
    logic       frame_start_q;
    logic [7:0] frame_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_start_q <= 1'b0;
            frame_cnt_q   <= 8'd0;
        end else begin
            frame_start_q <= rd_go && (rd_beat_q == '0);
            if (rd_go && (rd_beat_q == LAST_BEAT)) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
        end
    end

    assign frame_start_out = frame_start_q;
    assign frame_cnt_out   = frame_cnt_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_beat_q   <= '0;
            wr_bank_q   <= 1'b0;
            rd_beat_q   <= '0;
            rd_bank_q   <= 1'b0;
            bank_full_q <= 2'b00;
            valid_q     <= 1'b0;
            data_re_q   <= '0;
            data_im_q   <= '0;
        end else begin
            if (valid_in) begin
                wr_beat_q <= wr_beat_q + 1'b1;
                if (wr_beat_q == LAST_BEAT) begin
                    wr_bank_q <= ~wr_bank_q;
                end
            end
            bank_full_q <= bank_full_d;
            valid_q     <= rd_go;
            if (rd_go) begin
                data_re_q <= rd_re;
                data_im_q <= rd_im;
                rd_beat_q <= rd_beat_q + 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (rd_go) begin
                        state_q   <= S_READ;
                        rd_bank_q <= rd_sel_bank;
                    end
                end
                S_READ: begin
                    if (rd_beat_q == LAST_BEAT) begin
                        if (bank_full_q[~rd_bank_q]) begin
                            rd_bank_q <= ~rd_bank_q;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign valid_out   = valid_q;
    assign data_re_out = data_re_q;
    assign data_im_out = data_im_q;

endmodule

// File: tb/tb_cbfp_bitrev_reorder.sv
// Directed bench for cbfp_bitrev_reorder: vector table, per-beat scoreboard,
// burst-length and latency checks, reset corner cases.
module tb_cbfp_bitrev_reorder;

    localparam int DW    = 13;
    localparam int L     = 16;
    localparam int N     = 512;
    localparam int AW    = 9;
    localparam int BEATS = 32;
    localparam int BW    = 2 * L * DW;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            valid_in;
    logic [L*DW-1:0] data_re_in;
    logic [L*DW-1:0] data_im_in;
    logic            valid_out;
    logic [L*DW-1:0] data_re_out;
    logic [L*DW-1:0] data_im_out;
`ifdef CBFP_REORDER_FRAME_TAG_EN
    logic            frame_start_out;
    logic [7:0]      frame_cnt_out;
    int              fs_cnt;
`endif

    cbfp_bitrev_reorder #(
        .DATA_W(DW), .LANES(L), .N_PTS(N), .ADDR_W(AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_in    (valid_in),
        .data_re_in  (data_re_in),
        .data_im_in  (data_im_in),
        .valid_out   (valid_out),
        .data_re_out (data_re_out),
        .data_im_out (data_im_out)
`ifdef CBFP_REORDER_FRAME_TAG_EN
        ,
        .frame_start_out (frame_start_out),
        .frame_cnt_out   (frame_cnt_out)
`endif
    );

    // Clock and cycle index (cyc == number of rising edges seen so far)
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic [BW-1:0]       exp_q[$];
    logic [BW-1:0]       cap_q[$];
    int                  runs_q[$];
    int                  rise_q[$];
    int                  run_len = 0;
    logic                prev_v  = 1'b0;
    logic [BW-1:0]       mon_act;
    int                  last_cap;
    logic signed [DW-1:0] fr_re[N];
    logic signed [DW-1:0] fr_im[N];

    typedef struct {
        int idx;
        int re;
        int im;
    } vec_t;
    vec_t tbl[8];

    task automatic check_vec(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic int brev(input int m);
        int r = 0;
        for (int i = 0; i < AW; i++) r |= ((m >> i) & 1) << (AW - 1 - i);
        return r;
    endfunction

    function automatic int lane_re(input logic [BW-1:0] b, input int l);
        logic signed [DW-1:0] t;
        t = b[L*DW + l*DW +: DW];
        return int'(t);
    endfunction

    function automatic int lane_im(input logic [BW-1:0] b, input int l);
        logic signed [DW-1:0] t;
        t = b[l*DW +: DW];
        return int'(t);
    endfunction

    // Scoreboard monitor: sampled on the falling edge
    always @(negedge clk) begin
        if (valid_out) begin
            mon_act = {data_re_out, data_im_out};
            if (!prev_v) rise_q.push_back(cyc);
            run_len++;
            cap_q.push_back(mon_act);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got %h want none", mon_act);
            end else begin
                check_vec("beat", mon_act, exp_q.pop_front());
            end
        end else if (prev_v) begin
            runs_q.push_back(run_len);
            run_len = 0;
        end
`ifdef CBFP_REORDER_FRAME_TAG_EN
        if (frame_start_out && valid_out) fs_cnt++;
`endif
        prev_v = valid_out;
    end

    task automatic clear_mon();
        cap_q.delete();
        runs_q.delete();
        rise_q.delete();
        run_len = 0;
`ifdef CBFP_REORDER_FRAME_TAG_EN
        fs_cnt = 0;
`endif
    endtask

    task automatic set_ramp(input int off);
        for (int n = 0; n < N; n++) begin
            fr_re[n] = DW'(n + off);
            fr_im[n] = DW'(-(n + off));
        end
    endtask

    task automatic push_expected();
        logic [L*DW-1:0] re_f;
        logic [L*DW-1:0] im_f;
        for (int c = 0; c < BEATS; c++) begin
            for (int l = 0; l < L; l++) begin
                re_f[l*DW +: DW] = fr_re[brev(c*L + l)];
                im_f[l*DW +: DW] = fr_im[brev(c*L + l)];
            end
            exp_q.push_back({re_f, im_f});
        end
    endtask

    task automatic idle_beat();
        @(negedge clk);
        valid_in = 1'b0;
        for (int l = 0; l < L; l++) begin
            data_re_in[l*DW +: DW] = DW'($urandom);
            data_im_in[l*DW +: DW] = DW'($urandom);
        end
    endtask

    task automatic drive_frame(input bit gappy, input int nbeats, input bit push);
        if (push) push_expected();
        for (int c = 0; c < nbeats; c++) begin
            if (gappy && c != 0) repeat ($urandom_range(0, 1)) idle_beat();
            @(negedge clk);
            valid_in = 1'b1;
            for (int l = 0; l < L; l++) begin
                data_re_in[l*DW +: DW] = fr_re[c*L + l];
                data_im_in[l*DW +: DW] = fr_im[c*L + l];
            end
            last_cap = cyc + 1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        valid_in   = 1'b0;
        data_re_in = '0;
        data_im_in = '0;
        repeat (2) @(negedge clk);
        check_int("reset_valid", int'(valid_out), 0);
        check_vec("reset_data", {data_re_out, data_im_out}, '0);
`ifdef CBFP_REORDER_FRAME_TAG_EN
        check_int("reset_frame_cnt", int'(frame_cnt_out), 0);
`endif
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        clear_mon();
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || valid_out || prev_v) && n < 400) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check_int("drain_in_time", int'(n < 400), 1);
    endtask

    task automatic check_burst(input string name, input int len, input int exp_rise);
        check_int({name, "_num_bursts"}, runs_q.size(), 1);
        check_int({name, "_burst_len"}, (runs_q.size() > 0) ? runs_q[0] : -1, len);
        check_int({name, "_latency"}, (rise_q.size() > 0) ? rise_q[0] : -1, exp_rise);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lc;
        // Output index -> hand-computed natural-order sample for a ramp frame
        tbl[0] = '{0,     0,    0};
        tbl[1] = '{1,   256, -256};
        tbl[2] = '{2,   128, -128};
        tbl[3] = '{3,   384, -384};
        tbl[4] = '{16,   16,  -16};
        tbl[5] = '{17,  272, -272};
        tbl[6] = '{5,   320, -320};
        tbl[7] = '{511, 511, -511};

        rst_n      = 1'b0;
        valid_in   = 1'b0;
        data_re_in = '0;
        data_im_in = '0;

        // Single ramp frame
        do_reset();
        set_ramp(0);
        drive_frame(1'b0, BEATS, 1'b1);
        lc = last_cap;
        idle_beat();
        wait_drain();
        check_burst("ramp", 32, lc + 1);
        for (int i = 0; i < 8; i++) begin
            check_int($sformatf("tbl_re_%0d", tbl[i].idx),
                      lane_re(cap_q[tbl[i].idx / L], tbl[i].idx % L), tbl[i].re);
            check_int($sformatf("tbl_im_%0d", tbl[i].idx),
                      lane_im(cap_q[tbl[i].idx / L], tbl[i].idx % L), tbl[i].im);
        end
        check_vec("hold_after_burst", {data_re_out, data_im_out}, cap_q[BEATS-1]);
`ifdef CBFP_REORDER_FRAME_TAG_EN
        check_int("ramp_frame_cnt", int'(frame_cnt_out), 1);
        check_int("ramp_frame_start", fs_cnt, 1);
`endif

        // Four back-to-back frames
        do_reset();
        for (int f = 0; f < 4; f++) begin
            set_ramp(1000 * f);
            drive_frame(1'b0, BEATS, 1'b1);
            if (f == 0) lc = last_cap;
        end
        idle_beat();
        wait_drain();
        check_burst("b2b", 128, lc + 1);
        check_int("b2b_beats", cap_q.size(), 128);
`ifdef CBFP_REORDER_FRAME_TAG_EN
        check_int("b2b_frame_cnt", int'(frame_cnt_out), 4);
        check_int("b2b_frame_start", fs_cnt, 4);
`endif

        // Gappy input frame
        do_reset();
        set_ramp(0);
        drive_frame(1'b1, BEATS, 1'b1);
        lc = last_cap;
        idle_beat();
        wait_drain();
        check_burst("gappy", 32, lc + 1);

        // Reset after input beat 20, then a clean frame
        do_reset();
        set_ramp(300);
        drive_frame(1'b0, 21, 1'b0);
        @(negedge clk);
        rst_n    = 1'b0;
        valid_in = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check_int("abort_no_output", cap_q.size() + runs_q.size(), 0);
        set_ramp(7);
        drive_frame(1'b0, BEATS, 1'b1);
        lc = last_cap;
        idle_beat();
        wait_drain();
        check_burst("after_abort", 32, lc + 1);

        // Extreme values
        do_reset();
        for (int n = 0; n < N; n++) begin
            fr_re[n] = -13'sd4096;
            fr_im[n] = 13'sd4095;
        end
        drive_frame(1'b0, BEATS, 1'b1);
        idle_beat();
        wait_drain();
        check_int("extreme_re_first", lane_re(cap_q[0], 0), -4096);
        check_int("extreme_im_first", lane_im(cap_q[0], 0), 4095);
        check_int("extreme_re_last", lane_re(cap_q[BEATS-1], L-1), -4096);
        check_int("extreme_im_last", lane_im(cap_q[BEATS-1], L-1), 4095);

        // Asynchronous reset during output beat 10
        do_reset();
        set_ramp(0);
        drive_frame(1'b0, BEATS, 1'b1);
        idle_beat();
        repeat (11) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_int("async_reset_valid", int'(valid_out), 0);
        exp_q.delete();
        @(negedge clk);
        check_int("beats_before_reset", cap_q.size(), 10);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_mon();
        set_ramp(2000);
        drive_frame(1'b0, BEATS, 1'b1);
        lc = last_cap;
        idle_beat();
        wait_drain();
        check_burst("after_out_reset", 32, lc + 1);
        check_int("new_frame_beat0_re", lane_re(cap_q[0], 1), 2256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
